uc: RTL and testbench

UC -- requirements
Module: uc

---
 rtl/uc.sv | 171 +++++++++++++++++
 tb/tb_uc.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uc.sv
// Stack-machine control unit: fetches 10-bit instructions from ROM and sequences
// RAM, stack, temp-register and ALU-writeback strobes as Moore outputs of the state.
module uc (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  inst,
  input  logic [15:0] data_mem,
  input  logic        controle_ula,
  output logic        pilha_wren,
  output logic        controle_pilha,
  output logic        clock_pilha,
  output logic        clock_rom,
  output logic [4:0]  a_rom,
  output logic [15:0] data_pilha,
  output logic [4:0]  a_ram,
  output logic        clock_ram,
  output logic        ram_wren,
  output logic        load_temp1,
  output logic        clock_temp1,
  output logic        load_temp2,
  output logic        clock_temp2,
  output logic [4:0]  opcode
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StRamRd  = 4'd2,
    StPush   = 4'd3,
    StRamWr  = 4'd4,
    StPop    = 4'd5,
    StT1     = 4'd6,
    StPopA   = 4'd7,
    StT2     = 4'd8,
    StPopB   = 4'd9,
    StWb     = 4'd10,
    StHalt   = 4'd11
  } estado_t;

  localparam logic [4:0] OpNot = 5'd12;

  estado_t     estado_atual, estado_prox;
  logic [4:0]  pc_q, pc_d;
  logic [9:0]  ir_q, ir_d;          // ir_q[9:5] is the latched opcode
  logic [15:0] data_pilha_q, data_pilha_d;

  logic [4:0]  pc_inc;
  assign pc_inc = pc_q + 5'd1;      // 5-bit add wraps 31 -> 0

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_atual <= StFetch;
      pc_q         <= 5'd0;
      ir_q         <= 10'd0;
      data_pilha_q <= 16'd0;
    end else begin
      estado_atual <= estado_prox;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      data_pilha_q <= data_pilha_d;
    end
  end

  // Next-state, PC, IR and stack-data update.
  always_comb begin
    estado_prox  = estado_atual;
    pc_d         = pc_q;
    ir_d         = ir_q;
    data_pilha_d = data_pilha_q;
    unique case (estado_atual)
      StFetch:  estado_prox = StDecode;
      StDecode: begin
        ir_d = inst;
        case (inst[9:5])
          5'd0: estado_prox = StRamRd;
          5'd1: begin
            data_pilha_d = {11'b0, inst[4:0]};
            estado_prox  = StPush;
          end
          5'd2: estado_prox = StPop;
          5'd3: estado_prox = StRamWr;
          5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12:
            estado_prox = StT1;
          5'd13: begin
            pc_d        = inst[4:0];
            estado_prox = StFetch;
          end
          5'd14: begin
            pc_d        = controle_ula ? inst[4:0] : pc_inc;
            estado_prox = StFetch;
          end
          5'd15: estado_prox = StHalt;
          default: begin
            pc_d        = pc_inc;
            estado_prox = StFetch;
          end
        endcase
      end
      StRamRd: begin
        data_pilha_d = data_mem;
        estado_prox  = StPush;
      end
      StRamWr: estado_prox = StPop;
      StT1:    estado_prox = StPopA;
      StPopA:  estado_prox = (ir_q[9:5] == OpNot) ? StWb : StT2;
      StT2:    estado_prox = StPopB;
      StPopB:  estado_prox = StWb;
      StWb: begin
        data_pilha_d = data_mem;
        pc_d         = pc_inc;
        estado_prox  = StFetch;
      end
      StPush, StPop: begin
        pc_d        = pc_inc;
        estado_prox = StFetch;
      end
      StHalt:  estado_prox = StHalt;
      default: estado_prox = StFetch;
    endcase
  end

  // Moore strobes; gated by reset so they drop the instant reset is asserted.
  always_comb begin
    pilha_wren     = 1'b0;
    controle_pilha = 1'b0;
    clock_pilha    = 1'b0;
    clock_rom      = 1'b0;
    clock_ram      = 1'b0;
    ram_wren       = 1'b0;
    load_temp1     = 1'b0;
    clock_temp1    = 1'b0;
    load_temp2     = 1'b0;
    clock_temp2    = 1'b0;
    if (reset) begin
      case (estado_atual)
        StFetch: clock_rom = 1'b1;
        StRamRd: clock_ram = 1'b1;
        StRamWr: begin
          clock_ram = 1'b1;
          ram_wren  = 1'b1;
        end
        StPush, StWb: begin
          pilha_wren     = 1'b1;
          controle_pilha = 1'b1;
          clock_pilha    = 1'b1;
        end
        StPop, StPopA, StPopB: begin
          pilha_wren  = 1'b1;
          clock_pilha = 1'b1;
        end
        StT1: begin
          load_temp1  = 1'b1;
          clock_temp1 = 1'b1;
        end
        StT2: begin
          load_temp2  = 1'b1;
          clock_temp2 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ALU result is only valid on data_mem during WB, so pass it straight through.
  assign data_pilha = (estado_atual == StWb) ? data_mem : data_pilha_q;
  assign a_rom      = pc_q;
  assign a_ram      = ir_q[4:0];
  assign opcode     = ir_q[9:5];

endmodule

// File: tb/tb_uc.sv
// Scoreboard bench for uc: stimulus queues expected strobe events, a negedge
// monitor pops and compares them whenever any strobe is active.
module tb_uc;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  inst;
  logic [15:0] data_mem;
  logic        controle_ula;
  logic        pilha_wren, controle_pilha, clock_pilha, clock_rom;
  logic [4:0]  a_rom, a_ram, opcode;
  logic [15:0] data_pilha;
  logic        clock_ram, ram_wren, load_temp1, clock_temp1, load_temp2, clock_temp2;

  uc dut (
    .clock         (clk),
    .reset         (reset),
    .inst          (inst),
    .data_mem      (data_mem),
    .controle_ula  (controle_ula),
    .pilha_wren    (pilha_wren),
    .controle_pilha(controle_pilha),
    .clock_pilha   (clock_pilha),
    .clock_rom     (clock_rom),
    .a_rom         (a_rom),
    .data_pilha    (data_pilha),
    .a_ram         (a_ram),
    .clock_ram     (clock_ram),
    .ram_wren      (ram_wren),
    .load_temp1    (load_temp1),
    .clock_temp1   (clock_temp1),
    .load_temp2    (load_temp2),
    .clock_temp2   (clock_temp2),
    .opcode        (opcode)
  );

  always #5 clk = ~clk;

  // Strobe vector: {rom, ram, ram_wren, pilha_wren, ctl_pilha, clk_pilha, ld_t1, clk_t1, ld_t2, clk_t2}
  localparam logic [9:0] SRom  = 10'b1000000000;
  localparam logic [9:0] SRrd  = 10'b0100000000;
  localparam logic [9:0] SRwr  = 10'b0110000000;
  localparam logic [9:0] SPush = 10'b0001110000;
  localparam logic [9:0] SPop  = 10'b0001010000;
  localparam logic [9:0] ST1   = 10'b0000001100;
  localparam logic [9:0] ST2   = 10'b0000000011;

  typedef struct packed {
    logic [3:0]  st;
    logic [4:0]  pc;
    logic [9:0]  strb;
    logic [4:0]  ar;
    logic [15:0] dp;
    logic [4:0]  op;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  logic [9:0] strb_now;
  logic [3:0] st_now;
  assign strb_now = {clock_rom, clock_ram, ram_wren, pilha_wren, controle_pilha, clock_pilha,
                     load_temp1, clock_temp1, load_temp2, clock_temp2};
  assign st_now   = dut.estado_atual;

  task automatic ev(input logic [3:0] st, input logic [4:0] pc, input logic [9:0] strb,
                    input logic [4:0] ar, input logic [15:0] dp, input logic [4:0] op);
    ev_t e;
    e.st = st; e.pc = pc; e.strb = strb; e.ar = ar; e.dp = dp; e.op = op;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic [4:0] op, input logic [4:0] opr, input logic [15:0] dm,
                     input logic ula, input int ncyc);
    inst         = {op, opr};
    data_mem     = dm;
    controle_ula = ula;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe cycle must match the next queued event.
  ev_t e_m;
  logic ok_m;
  always @(negedge clk) begin
    if (reset === 1'b1 && strb_now != 10'd0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: state=%0d pc=%0d strb=%b", st_now, a_rom, strb_now);
      end else begin
        e_m  = exp_q.pop_front();
        ok_m = (st_now == e_m.st) && (a_rom == e_m.pc) && (strb_now == e_m.strb);
        if (clock_ram) ok_m = ok_m && (a_ram == e_m.ar);
        if (clock_pilha && controle_pilha) ok_m = ok_m && (data_pilha == e_m.dp);
        if (st_now != 4'd0) ok_m = ok_m && (opcode == e_m.op);
        if (!ok_m) begin
          bad++;
          $display("FAIL event: got st=%0d pc=%0d strb=%b ar=%0d dp=%h op=%0d expected st=%0d pc=%0d strb=%b ar=%0d dp=%h op=%0d",
                   st_now, a_rom, strb_now, a_ram, data_pilha, opcode,
                   e_m.st, e_m.pc, e_m.strb, e_m.ar, e_m.dp, e_m.op);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; inst = 10'd0; data_mem = 16'd0; controle_ula = 1'b0;
    #2;
    chk("reset_state", 32'(st_now), 0);
    chk("reset_strobes", 32'(strb_now), 0);
    chk("reset_pc", 32'(a_rom), 0);
    #5;
    reset = 1'b1;
    // PUSH_I 7
    ev(0, 0, SRom, 0, 0, 0); ev(3, 0, SPush, 0, 16'd7, 5'd1);
    run(5'd1, 5'd7, 16'd0, 1'b0, 3);
    chk("pc_after_push_i", 32'(a_rom), 1);
    // PUSH from RAM[9]
    ev(0, 1, SRom, 0, 0, 0); ev(2, 1, SRrd, 5'd9, 0, 5'd0); ev(3, 1, SPush, 0, 16'hABCD, 5'd0);
    run(5'd0, 5'd9, 16'hABCD, 1'b0, 4);
    // ADD
    ev(0, 2, SRom, 0, 0, 0); ev(6, 2, ST1, 0, 0, 5'd4); ev(7, 2, SPop, 0, 0, 5'd4);
    ev(8, 2, ST2, 0, 0, 5'd4); ev(9, 2, SPop, 0, 0, 5'd4); ev(10, 2, SPush, 0, 16'h0005, 5'd4);
    run(5'd4, 5'd0, 16'h0005, 1'b0, 7);
    // POP to RAM[12]
    ev(0, 3, SRom, 0, 0, 0); ev(4, 3, SRwr, 5'd12, 0, 5'd3); ev(5, 3, SPop, 0, 0, 5'd3);
    run(5'd3, 5'd12, 16'd0, 1'b0, 4);
    // DROP
    ev(0, 4, SRom, 0, 0, 0); ev(5, 4, SPop, 0, 0, 5'd2);
    run(5'd2, 5'd0, 16'd0, 1'b0, 3);
    // NOT
    ev(0, 5, SRom, 0, 0, 0); ev(6, 5, ST1, 0, 0, 5'd12); ev(7, 5, SPop, 0, 0, 5'd12);
    ev(10, 5, SPush, 0, 16'h1234, 5'd12);
    run(5'd12, 5'd0, 16'h1234, 1'b0, 5);
    // GOTO 20, IF not taken, IF taken, NOP
    ev(0, 6, SRom, 0, 0, 0);  run(5'd13, 5'd20, 16'd0, 1'b0, 2);
    ev(0, 20, SRom, 0, 0, 0); run(5'd14, 5'd3, 16'd0, 1'b0, 2);
    ev(0, 21, SRom, 0, 0, 0); run(5'd14, 5'd3, 16'd0, 1'b1, 2);
    ev(0, 3, SRom, 0, 0, 0);  run(5'd20, 5'd0, 16'd0, 1'b0, 2);
    // PUSH_I 31
    ev(0, 4, SRom, 0, 0, 0); ev(3, 4, SPush, 0, 16'd31, 5'd1);
    run(5'd1, 5'd31, 16'd0, 1'b0, 3);
    // SUB interrupted by reset during T2
    ev(0, 5, SRom, 0, 0, 0); ev(6, 5, ST1, 0, 0, 5'd5); ev(7, 5, SPop, 0, 0, 5'd5);
    ev(8, 5, ST2, 0, 0, 5'd5);
    run(5'd5, 5'd0, 16'd0, 1'b0, 4);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midalu_rst_state", 32'(st_now), 0);
    chk("midalu_rst_pc", 32'(a_rom), 0);
    chk("midalu_rst_strobes", 32'(strb_now), 0);
    chk("midalu_rst_data_pilha", 32'(data_pilha), 0);
    chk("midalu_rst_opcode", 32'(opcode), 0);
    @(posedge clk); #1;
    chk("rst_held_state", 32'(st_now), 0);
    reset = 1'b1;
    // PC wrap: GOTO 31, NOP at 31 -> 0, NOP at 0 -> 1
    ev(0, 0, SRom, 0, 0, 0);  run(5'd13, 5'd31, 16'd0, 1'b0, 2);
    ev(0, 31, SRom, 0, 0, 0); run(5'd20, 5'd0, 16'd0, 1'b0, 2);
    chk("pc_wrap", 32'(a_rom), 0);
    ev(0, 0, SRom, 0, 0, 0);  run(5'd20, 5'd0, 16'd0, 1'b0, 2);
    // HALT at PC 1
    ev(0, 1, SRom, 0, 0, 0);  run(5'd15, 5'd0, 16'd0, 1'b0, 2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      chk("halt_state", 32'(st_now), 11);
      chk("halt_pc", 32'(a_rom), 1);
    end
    chk("halt_strobes", 32'(strb_now), 0);
    reset = 1'b0;
    #1;
    chk("halt_rst_state", 32'(st_now), 0);
    chk("halt_rst_pc", 32'(a_rom), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    ev(0, 0, SRom, 0, 0, 0);  run(5'd20, 5'd0, 16'd0, 1'b0, 2);
    chk("pc_after_restart", 32'(a_rom), 1);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
